// File: rtl/button_debouncer.sv
// button_debouncer: per-channel 2-flop synchronizer, stability counter and
// 4-state debounce FSM. Each channel produces a registered debounced level and
// one-cycle press/release strobes for the display-mode logic.
// Optional feature macro: BUTTON_DEBOUNCER_REPEAT_EN adds auto-repeat press
// strobes while a button stays held (REPEAT_DELAY first, then every REPEAT_PERIOD).
module button_debouncer #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam logic [63:0] CNT_MAX = (64'(1) << CNT_W) - 64'(1);
  localparam bit CFG_LEGAL = (DEBOUNCE_CYCLES >= 1) &&
                             (64'(DEBOUNCE_CYCLES) <= CNT_MAX) &&
                             (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

  // Out-of-range configurations elaborate this marker scope so they stand out in the hierarchy
  if (!CFG_LEGAL) begin : g_cfg_out_of_range
  end

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  // Two-flop synchronizer for the asynchronous raw buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < int'(N_BTN); g++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_s;
    logic             w_cnt_done;
    logic             w_accept_press;
    logic             w_rpt_fire;

    assign w_s            = r_sync2[g];
    assign w_cnt_done     = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign w_accept_press = (r_state == ST_PRESS_WAIT) && (w_state_nxt == ST_PRESSED);

    // FSM state and stability counter register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // Next-state and counter update; any disagreeing sample restarts the count
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_IDLE: begin
          if (w_s) begin
            w_state_nxt = ST_PRESS_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_s) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_cnt_done) begin
            w_state_nxt = ST_PRESSED;
            w_cnt_nxt   = '0;
          end else if (r_cnt != '1) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!w_s) begin
            w_state_nxt = ST_RELEASE_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (w_s) begin
            w_state_nxt = ST_PRESSED;
            w_cnt_nxt   = '0;
          end else if (w_cnt_done) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt != '1) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // Output decode from the transition being taken this cycle
    always_comb begin
      w_level_nxt   = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_WAIT);
      w_press_nxt   = w_accept_press || w_rpt_fire;
      w_release_nxt = (r_state == ST_RELEASE_WAIT) && (w_state_nxt == ST_IDLE);
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
      end
    end

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [RPT_W-1:0] r_rpt;
    logic [RPT_W-1:0] w_rpt_nxt;

    // Repeat down-counter: loaded on an accepted press, runs only in PRESSED, held otherwise
    always_comb begin
      w_rpt_nxt  = r_rpt;
      w_rpt_fire = 1'b0;
      if (w_accept_press) begin
        w_rpt_nxt = RPT_W'(REPEAT_DELAY - 1);
      end else if (r_state == ST_PRESSED) begin
        if (r_rpt == '0) begin
          w_rpt_fire = 1'b1;
          w_rpt_nxt  = RPT_W'(REPEAT_PERIOD - 1);
        end else begin
          w_rpt_nxt = r_rpt - RPT_W'(1);
        end
      end
    end

    // Repeat counter register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rpt <= '0;
      end else begin
        r_rpt <= w_rpt_nxt;
      end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: expected strobes are queued by the
// stimulus and matched by an independent monitor; levels are checked directly.
module tb_button_debouncer;

  localparam int unsigned N      = 2;
  localparam int unsigned DEB    = 8;
  localparam int unsigned RPT_D  = 20;
  localparam int unsigned RPT_P  = 5;
  // Cycles from driving raw (at a negedge) to the negedge where the strobe is seen
  localparam int unsigned LAT    = DEB + 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  typedef struct packed {
    int unsigned cyc;
    int unsigned ch;
    logic        is_press;
  } ev_t;

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;

  button_debouncer #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (4),
    .REPEAT_DELAY   (RPT_D),
    .REPEAT_PERIOD  (RPT_P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int unsigned ch, input logic is_press, input int unsigned at);
    ev_t e;
    e.cyc      = at;
    e.ch       = ch;
    e.is_press = is_press;
    exp_q.push_back(e);
  endtask

  task automatic check_vec(input string name, input logic [N-1:0] got, input logic [N-1:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %b required %b at cycle %0d", name, got, req, cyc);
    end
  endtask

  task automatic score(input int unsigned ch, input logic is_press);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL strobe_unexpected: got %s ch%0d at cycle %0d, required none",
               is_press ? "press" : "release", ch, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.ch != ch || e.is_press != is_press) begin
        n_errors++;
        $display("FAIL strobe_match: got %s ch%0d at cycle %0d, required %s ch%0d at cycle %0d",
                 is_press ? "press" : "release", ch, cyc,
                 e.is_press ? "press" : "release", e.ch, e.cyc);
      end
    end
  endtask

  // Monitor: every strobe seen must be the next queued expectation
  always @(negedge clk) begin
    for (int c = 0; c < int'(N); c++) begin
      if (btn_press[c])   score(c, 1'b1);
      if (btn_release[c]) score(c, 1'b0);
    end
  end

  initial begin
    int unsigned t;
    rst     = 1'b1;
    btn_raw = '0;
    tick(3);
    check_vec("reset_level", btn_level, 2'b00);
    check_vec("reset_press", btn_press, 2'b00);
    check_vec("reset_release", btn_release, 2'b00);
    rst = 1'b0;
    tick(3);
    check_vec("idle_level", btn_level, 2'b00);

    // Clean press and release on ch0
    t = cyc;
    btn_raw[0] = 1'b1;
    push(0, 1'b1, t + LAT);
    tick(LAT - 1);
    check_vec("press_lat_before", btn_level, 2'b00);
    tick(1);
    check_vec("press_lat_after", btn_level, 2'b01);
    tick(9);
    t = cyc;
    btn_raw[0] = 1'b0;
    push(0, 1'b0, t + LAT);
    tick(LAT - 1);
    check_vec("release_lat_before", btn_level, 2'b01);
    tick(1);
    check_vec("release_lat_after", btn_level, 2'b00);
    tick(3);

    // Bouncing press: only the final steady step counts
    btn_raw[0] = 1'b1; tick(3);
    btn_raw[0] = 1'b0; tick(3);
    btn_raw[0] = 1'b1; tick(3);
    btn_raw[0] = 1'b0; tick(3);
    t = cyc;
    btn_raw[0] = 1'b1;
    push(0, 1'b1, t + LAT);
    tick(LAT - 1);
    check_vec("bounce_before", btn_level, 2'b00);
    tick(5);
    check_vec("bounce_level", btn_level, 2'b01);

    // Glitch during release restarts the count
    btn_raw[0] = 1'b0; tick(7);
    btn_raw[0] = 1'b1; tick(1);
    t = cyc;
    btn_raw[0] = 1'b0;
    push(0, 1'b0, t + LAT);
    tick(LAT - 1);
    check_vec("glitch_level_held", btn_level, 2'b01);
    tick(1);
    check_vec("glitch_level_fall", btn_level, 2'b00);
    tick(3);

    // Async reset in the middle of a ch0 count while ch1 is pressed
    t = cyc;
    btn_raw[1] = 1'b1;
    push(1, 1'b1, t + LAT);
    tick(LAT + 1);
    check_vec("ch1_pressed", btn_level, 2'b10);
    btn_raw[0] = 1'b1;
    tick(5);
    #2 rst = 1'b1;
    #1;
    check_vec("async_rst_level", btn_level, 2'b00);
    check_vec("async_rst_press", btn_press, 2'b00);
    check_vec("async_rst_release", btn_release, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    t = cyc;
    push(0, 1'b1, t + LAT);
    push(1, 1'b1, t + LAT);
    tick(LAT - 1);
    check_vec("rst_repress_before", btn_level, 2'b00);
    tick(1);
    check_vec("rst_repress_after", btn_level, 2'b11);
    tick(3);
    t = cyc;
    btn_raw = 2'b00;
    push(0, 1'b0, t + LAT);
    push(1, 1'b0, t + LAT);
    tick(LAT + 3);
    check_vec("rst_released", btn_level, 2'b00);

    // Two channels, ch1 three cycles behind ch0
    t = cyc;
    btn_raw[0] = 1'b1;
    push(0, 1'b1, t + LAT);
    push(1, 1'b1, t + 3 + LAT);
    tick(3);
    btn_raw[1] = 1'b1;
    tick(LAT - 1);
    check_vec("offset_mid", btn_level, 2'b01);
    tick(2);
    check_vec("offset_both", btn_level, 2'b11);
    t = cyc;
    btn_raw = 2'b00;
    push(0, 1'b0, t + LAT);
    push(1, 1'b0, t + LAT);
    tick(LAT + 3);
    check_vec("offset_released", btn_level, 2'b00);

    // Long hold on ch0 (auto-repeat strobes when the feature is built in)
    t = cyc;
    btn_raw[0] = 1'b1;
    push(0, 1'b1, t + LAT);
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    for (int k = 0; k < 6; k++) push(0, 1'b1, t + LAT + RPT_D + k * RPT_P);
`endif
    tick(LAT + 45);
    check_vec("hold_level", btn_level, 2'b01);
    t = cyc;
    btn_raw[0] = 1'b0;
    push(0, 1'b0, t + LAT);
    tick(LAT + 5);
    check_vec("hold_released", btn_level, 2'b00);

    tick(5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drained: got %0d pending strobes, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
